// File: rtl/deframer_if.sv
// Stream bundle for the deframer: packed word input stream, unpacked element
// output stream and the framing status outputs.
// slave modport = deframer side, master modport = upstream/downstream side.
interface deframer_if #(
  parameter int unsigned UnpackedWidth = 1,
  parameter int unsigned PackedWidth   = 8
);
  logic                     valid_i;
  logic                     ready_o;
  logic [PackedWidth-1:0]   data_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [UnpackedWidth-1:0] unpacked_o;
  logic                     last_o;
  logic                     frame_ok_o;
  logic                     frame_err_o;
  logic [15:0]              err_count_o;

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, unpacked_o, last_o, frame_ok_o, frame_err_o, err_count_o
  );

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, unpacked_o, last_o, frame_ok_o, frame_err_o, err_count_o
  );
endinterface

// File: rtl/deframer.sv
// Length-based deframer: accepts PacketLenElems packed payload words, emits
// each as PackedNum elements (element 0 from the low bits first), then checks
// a two-word footer (TailByte0, TailByte1 on the low 8 bits of the word).
// A bad footer pulses frame_err_o once and hunts for TailByte0,TailByte1.
// Optional feature macro: DEFRAMER_ERR_COUNT_EN (saturating error counter on
// err_count_o; without it err_count_o is tied to zero).
module deframer #(
  parameter int unsigned UnpackedWidth  = 1,
  parameter int unsigned PackedNum      = 8,
  parameter int unsigned PackedWidth    = UnpackedWidth * PackedNum,
  parameter int unsigned PacketLenElems = 1024,
  parameter logic [7:0]  TailByte0      = 8'h0D,
  parameter logic [7:0]  TailByte1      = 8'h0A
) (
  input  logic      clk_i,
  input  logic      rst_i,
  deframer_if.slave bus
);
  localparam int unsigned CntW = (PacketLenElems > 1) ? $clog2(PacketLenElems) : 1;
  localparam int unsigned IdxW = (PackedNum > 1) ? $clog2(PackedNum) : 1;
  localparam logic [CntW-1:0] LastWord = CntW'(PacketLenElems - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PackedNum - 1);

  typedef enum logic [1:0] {
    ST_PAYLOAD = 2'd0,
    ST_TAIL0   = 2'd1,
    ST_TAIL1   = 2'd2,
    ST_RESYNC  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     armed_q, armed_d;
  logic [CntW-1:0]          word_cnt_q, word_cnt_d;
  logic [PackedWidth-1:0]   shreg_q, shreg_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic                     last_word_q, last_word_d;
  logic                     valid_q, valid_d;
  logic [UnpackedWidth-1:0] elem_q, elem_d;
  logic                     last_q, last_d;
  logic                     ok_q, ok_d;
  logic                     err_q, err_d;

  logic                     out_xfer;
  logic                     final_xfer;
  logic                     ready;
  logic                     in_xfer;
  logic [PackedWidth+7:0]   data_ext;
  logic                     is_t0;
  logic                     is_t1;

  assign out_xfer   = valid_q && bus.ready_i;
  assign final_xfer = out_xfer && (idx_q == LastIdx);
  assign in_xfer    = bus.valid_i && ready;
  // Zero-extend so the footer compare also works for words narrower than 8 bits.
  assign data_ext   = {8'd0, bus.data_i};
  assign is_t0      = (data_ext[7:0] == TailByte0);
  assign is_t1      = (data_ext[7:0] == TailByte1);

  // Input acceptance: payload words may chain onto the last element, footer words wait for an empty unpacker.
  always_comb begin
    if (state_q == ST_PAYLOAD) begin
      ready = !valid_q || final_xfer;
    end else begin
      ready = !valid_q;
    end
  end

  // Next-state logic for the framing FSM, the unpacker and the status pulses.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    word_cnt_d  = word_cnt_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    last_word_d = last_word_q;
    valid_d     = valid_q;
    elem_d      = elem_q;
    last_d      = last_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;

    // Output side: step to the next element or drain the unpacker.
    if (out_xfer) begin
      if (idx_q == LastIdx) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        elem_d  = shreg_q[UnpackedWidth-1:0];
        shreg_d = shreg_q >> UnpackedWidth;
        idx_d   = idx_q + IdxW'(1);
        last_d  = last_word_q && ((idx_q + IdxW'(1)) == LastIdx);
      end
    end else begin
      valid_d = valid_q;
    end

    // Input side: a payload load overrides the drain above when back-to-back.
    if (in_xfer) begin
      case (state_q)
        ST_PAYLOAD: begin
          elem_d      = bus.data_i[UnpackedWidth-1:0];
          shreg_d     = bus.data_i >> UnpackedWidth;
          idx_d       = IdxW'(0);
          valid_d     = 1'b1;
          last_word_d = (word_cnt_q == LastWord);
          last_d      = (word_cnt_q == LastWord) && (LastIdx == IdxW'(0));
          if (word_cnt_q == LastWord) begin
            word_cnt_d = CntW'(0);
            state_d    = ST_TAIL0;
          end else begin
            word_cnt_d = word_cnt_q + CntW'(1);
          end
        end
        ST_TAIL0: begin
          if (is_t0) begin
            state_d = ST_TAIL1;
          end else begin
            err_d   = 1'b1;
            armed_d = 1'b0;
            state_d = ST_RESYNC;
          end
        end
        ST_TAIL1: begin
          if (is_t1) begin
            ok_d       = 1'b1;
            word_cnt_d = CntW'(0);
            state_d    = ST_PAYLOAD;
          end else begin
            // A stray TailByte0 here may be the start of the real footer.
            err_d   = 1'b1;
            armed_d = is_t0;
            state_d = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (armed_q && is_t1) begin
            armed_d    = 1'b0;
            word_cnt_d = CntW'(0);
            state_d    = ST_PAYLOAD;
          end else begin
            armed_d = is_t0;
          end
        end
        default: begin
          armed_d    = 1'b0;
          word_cnt_d = CntW'(0);
          state_d    = ST_PAYLOAD;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_PAYLOAD;
      armed_q     <= 1'b0;
      word_cnt_q  <= CntW'(0);
      shreg_q     <= '0;
      idx_q       <= IdxW'(0);
      last_word_q <= 1'b0;
      valid_q     <= 1'b0;
      elem_q      <= '0;
      last_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      word_cnt_q  <= word_cnt_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      last_word_q <= last_word_d;
      valid_q     <= valid_d;
      elem_q      <= elem_d;
      last_q      <= last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = valid_q;
  assign bus.unpacked_o  = elem_q;
  assign bus.last_o      = last_q;
  assign bus.frame_ok_o  = ok_q;
  assign bus.frame_err_o = err_q;

`ifdef DEFRAMER_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of footer errors, stepped together with the error pulse.
  always_comb begin
    if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count_o = err_cnt_q;
`else
  assign bus.err_count_o = 16'd0;
`endif

endmodule
